mem_store_buffer: RTL and testbench
===================================

# mem_store_buffer

Posted-write store buffer between the processor core's memory ports and the abstract or real memory model. It accepts stores from the core without stalling, retires them to memory in order, one per acknowledged cycle, and forwards buffered data to same-address loads so the core always sees program-order memory. A drain request empties the buffer before instruction-end comparison, so the memory abstraction compares only retired state.

## Interface
Parameters:
- AW, 8, address width
- DW, 8, data width
- DEPTH, 4, entry count; power of two, at least 2

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- up_w_en  in  1  core store request
- up_w_addr  in  AW  store address
- up_w_data  in  DW  store data
- up_w_ready  out  1  buffer can accept a store this cycle
- up_r_en  in  1  core load request
- up_r_addr  in  AW  load address
- up_r_data  out  DW  load data, same cycle
- dn_w_en  out  1  head entry valid toward memory
- dn_w_addr  out  AW  head address
- dn_w_data  out  DW  head data
- dn_w_ack  in  1  memory accepted head this cycle
- dn_r_en  out  1  load forwarded to memory (miss)
- dn_r_addr  out  AW  equals up_r_addr
- dn_r_data  in  DW  memory load data
- drain_req  in  1  request empty-out
- drained  out  1  one-cycle pulse when a drain completes
- count  out  $clog2(DEPTH)+1  occupied entries
- err_ovf  out  1  sticky: store dropped

## Operation
- Circular FIFO with head and tail pointers of width $clog2(DEPTH) that wrap modulo DEPTH. Each entry stores addr and data.
- Push: up_w_en && up_w_ready writes to tail, then tail+1.
- up_w_ready = (count < DEPTH) && state==RUN. There is no same-cycle bypass when full.
- up_w_en while !up_w_ready: the store is dropped and err_ovf sets. err_ovf clears only on rst.
- Retire: dn_w_en = (count != 0), with dn_w_* driven from the head. dn_w_ack while dn_w_en pops the head. An ack while empty is ignored.
- Push and pop in the same cycle leave count unchanged. The pushed entry may not be the popped one.
- Load, combinational: search valid entries for addr == up_r_addr.
  - Hit: up_r_data is the youngest matching entry (closest to tail) and dn_r_en=0.
  - Miss: dn_r_en=up_r_en and up_r_data=dn_r_data.
  - A store pushed in the same cycle is not visible to that cycle's load.
- FSM states:
  - RUN: drain_req goes to DRAIN, or to DONE if count==0.
  - DRAIN: pushes are blocked. Leaves for DONE in the cycle count becomes 0.
  - DONE: drained=1 for exactly one cycle, then RUN.
  - drain_req is ignored outside RUN.
- Reset mid-operation discards all entries without retiring them.

## Timing
- Reset values: count=0, pointers=0, state=RUN, dn_w_en=0, drained=0, err_ovf=0, up_w_ready=1.
- Push-to-retire latency: an entry pushed in cycle N can appear on dn_w_* at cycle N+1 at the earliest.
- Load forwarding and the miss path both have zero latency.
- Maximum throughput is one push and one pop per cycle.
- Drain latency is the count at request plus ack stall cycles plus 1 (the DONE cycle).

## Structure
- Package mem_sb_pkg holds the FSM enum sb_state_e {SB_RUN, SB_DRAIN, SB_DONE}.
- Sub-module mem_sb_fwd_match takes entry valid/addr/data vectors plus the head pointer. It returns hit and youngest-match data.
- The match is a priority search from tail-1 back to head, with modulo wrap.

## Test plan
- Reset, then push (0x10,0xAA) with ack held 1: dn_w_en asserts at cycle+1 with 0x10/0xAA, then count returns to 0.
- Push 0x05→0x11, then 0x05→0x22, with ack=0; load 0x05: up_r_data=0x22 and dn_r_en=0. Load 0x06 with dn_r_data=0x7E: up_r_data=0x7E and dn_r_en=1.
- Fill DEPTH=4 with ack=0: up_w_ready=0 and count=4. A fifth store sets err_ovf and leaves the entry data intact.
- Wrap-around: 6 pushes with ack on alternating cycles. Retire order and addresses match push order; pointers wrap with no loss.
- 3 entries buffered, drain_req with ack held 1: up_w_ready=0 during DRAIN. drained pulses exactly once, 4 cycles after the request.
- rst asserted with 2 entries buffered: next cycle count=0 and dn_w_en=0, with no ack needed.

Source files
------------

// File: rtl/mem_sb_pkg.sv
// Shared types for the posted-write store buffer.
package mem_sb_pkg;

    typedef enum logic [1:0] {
        SB_RUN,
        SB_DRAIN,
        SB_DONE
    } sb_state_e;

endpackage

// File: rtl/mem_sb_fwd_match.sv
// Store-to-load forwarding: finds the youngest buffered store matching a load address.
// Latency: combinational.
// Backpressure: none.
module mem_sb_fwd_match #(
    parameter int AW    = 8,
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]         valid_i,
    input  logic [DEPTH-1:0][AW-1:0] addr_i,
    input  logic [DEPTH-1:0][DW-1:0] data_i,
    input  logic [$clog2(DEPTH)-1:0] head_i,
    input  logic [AW-1:0]            match_addr_i,
    output logic                     hit_o,
    output logic [DW-1:0]            data_o
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] idx;

    // Walk oldest to youngest so the last hit wins; valid entries are contiguous
    // from head, so this equals a priority search from tail-1 back to head.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_i + PW'(k);
            if (valid_i[idx] && (addr_i[idx] == match_addr_i)) begin
                hit_o  = 1'b1;
                data_o = data_i[idx];
            end
        end
    end

endmodule

// File: rtl/mem_store_buffer.sv
// Posted-write store buffer: in-order retire to memory, forwards buffered data to loads.
// Latency: push visible on dn_w_* next cycle; load forward/miss path combinational.
// Backpressure: up_w_ready low when full or draining; stores offered anyway are dropped and flag err_ovf.
module mem_store_buffer
    import mem_sb_pkg::*;
#(
    parameter int AW    = 8,
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     up_w_en,
    input  logic [AW-1:0]            up_w_addr,
    input  logic [DW-1:0]            up_w_data,
    output logic                     up_w_ready,
    input  logic                     up_r_en,
    input  logic [AW-1:0]            up_r_addr,
    output logic [DW-1:0]            up_r_data,
    output logic                     dn_w_en,
    output logic [AW-1:0]            dn_w_addr,
    output logic [DW-1:0]            dn_w_data,
    input  logic                     dn_w_ack,
    output logic                     dn_r_en,
    output logic [AW-1:0]            dn_r_addr,
    input  logic [DW-1:0]            dn_r_data,
    input  logic                     drain_req,
    output logic                     drained,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_ovf
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sb_state_e                state_q;
    logic                     drained_q;
    logic                     err_q;
    logic [PW-1:0]            head_q, tail_q;
    logic [CW-1:0]            count_q, count_d;
    logic [DEPTH-1:0][AW-1:0] addr_mem_q;
    logic [DEPTH-1:0][DW-1:0] data_mem_q;
    logic [DEPTH-1:0]         valid;
    logic [PW-1:0]            off;
    logic                     push, pop, hit;
    logic [DW-1:0]            fwd_data;

    assign up_w_ready = (count_q < CW'(DEPTH)) && (state_q == SB_RUN);
    assign push       = up_w_en && up_w_ready;
    assign dn_w_en    = (count_q != '0);
    assign pop        = dn_w_ack && dn_w_en;
    assign dn_w_addr  = addr_mem_q[head_q];
    assign dn_w_data  = data_mem_q[head_q];
    assign count      = count_q;
    assign err_ovf    = err_q;
    assign drained    = drained_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // An entry is live when its distance from head is below the occupancy.
    always_comb begin
        valid = '0;
        off   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off      = PW'(i) - head_q;
            valid[i] = ({1'b0, off} < count_q);
        end
    end

    mem_sb_fwd_match #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fwd_match (
        .valid_i      (valid),
        .addr_i       (addr_mem_q),
        .data_i       (data_mem_q),
        .head_i       (head_q),
        .match_addr_i (up_r_addr),
        .hit_o        (hit),
        .data_o       (fwd_data)
    );

    assign dn_r_addr = up_r_addr;
    assign dn_r_en   = up_r_en && !hit;
    assign up_r_data = hit ? fwd_data : dn_r_data;

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[tail_q] <= up_w_addr;
            data_mem_q[tail_q] <= up_w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) begin
                tail_q <= tail_q + PW'(1);
            end
            if (pop) begin
                head_q <= head_q + PW'(1);
            end
            if (up_w_en && !up_w_ready) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SB_RUN;
            drained_q <= 1'b0;
        end else begin
            drained_q <= 1'b0;
            case (state_q)
                SB_RUN: begin
                    if (drain_req) begin
                        if (count_q == '0) begin
                            state_q   <= SB_DONE;
                            drained_q <= 1'b1;
                        end else begin
                            state_q <= SB_DRAIN;
                        end
                    end
                end
                SB_DRAIN: begin
                    if (count_q == '0) begin
                        state_q   <= SB_DONE;
                        drained_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= SB_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_store_buffer.sv
// Directed table-driven bench for mem_store_buffer plus a hand-written drain sequence.
module tb_mem_store_buffer;

    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;

    logic       clk = 1'b0;
    logic       rst;
    logic       up_w_en, up_r_en, dn_w_ack, drain_req;
    logic [7:0] up_w_addr, up_w_data, up_r_addr, dn_r_data;
    logic       up_w_ready, dn_w_en, dn_r_en, drained, err_ovf;
    logic [7:0] up_r_data, dn_w_addr, dn_w_data, dn_r_addr;
    logic [2:0] count;

    always #5 clk = ~clk;

    mem_store_buffer #(.AW(8), .DW(8), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_w_en    (up_w_en),
        .up_w_addr  (up_w_addr),
        .up_w_data  (up_w_data),
        .up_w_ready (up_w_ready),
        .up_r_en    (up_r_en),
        .up_r_addr  (up_r_addr),
        .up_r_data  (up_r_data),
        .dn_w_en    (dn_w_en),
        .dn_w_addr  (dn_w_addr),
        .dn_w_data  (dn_w_data),
        .dn_w_ack   (dn_w_ack),
        .dn_r_en    (dn_r_en),
        .dn_r_addr  (dn_r_addr),
        .dn_r_data  (dn_r_data),
        .drain_req  (drain_req),
        .drained    (drained),
        .count      (count),
        .err_ovf    (err_ovf)
    );

    typedef struct packed {
        logic       rst, w_en;
        logic [7:0] w_addr, w_data;
        logic       r_en;
        logic [7:0] r_addr, dnr;
        logic       ack, drain;
    } in_t;

    typedef struct packed {
        logic       rdy;
        logic [7:0] rd;
        logic       dnr_en, dnw_en;
        logic [7:0] dwa, dwd;
        logic [2:0] cnt;
        logic       err, drained;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    function automatic in_t vi(input logic r, input logic we, input logic [7:0] wa,
                               input logic [7:0] wd, input logic re, input logic [7:0] ra,
                               input logic [7:0] dnr, input logic ack, input logic dr);
        in_t a;
        a.rst = r; a.w_en = we; a.w_addr = wa; a.w_data = wd; a.r_en = re;
        a.r_addr = ra; a.dnr = dnr; a.ack = ack; a.drain = dr;
        return a;
    endfunction

    function automatic out_t vo(input logic rdy, input logic [7:0] rd, input logic dnre,
                                input logic dnwe, input logic [7:0] dwa, input logic [7:0] dwd,
                                input logic [2:0] cnt, input logic err, input logic drn);
        out_t o;
        o.rdy = rdy; o.rd = rd; o.dnr_en = dnre; o.dnw_en = dnwe; o.dwa = dwa;
        o.dwd = dwd; o.cnt = cnt; o.err = err; o.drained = drn;
        return o;
    endfunction

    task automatic add(input in_t a, input out_t o);
        vec_t v;
        v.i = a;
        v.o = o;
        tbl.push_back(v);
    endtask

    task automatic apply(input in_t a);
        rst = a.rst; up_w_en = a.w_en; up_w_addr = a.w_addr; up_w_data = a.w_data;
        up_r_en = a.r_en; up_r_addr = a.r_addr; dn_r_data = a.dnr;
        dn_w_ack = a.ack; drain_req = a.drain;
    endtask

    function automatic out_t sample();
        return vo(up_w_ready, up_r_data, dn_r_en, dn_w_en, dn_w_addr, dn_w_data,
                  count, err_ovf, drained);
    endfunction

    function automatic string fmt(input out_t o);
        return $sformatf("rdy=%b rd=%h dnr_en=%b dnw_en=%b dnw=%h/%h cnt=%0d err=%b drained=%b",
                         o.rdy, o.rd, o.dnr_en, o.dnw_en, o.dwa, o.dwd, o.cnt, o.err, o.drained);
    endfunction

    task automatic check_vec(input string name, input out_t got, input out_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got {%s} want {%s}", name, fmt(got), fmt(exp));
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, exp);
        end
    endtask

    initial begin
        out_t got;
        int   first;
        int   pulses;

        apply(vi(Y, N, 8'h00, 8'h00, N, 8'h00, 8'h00, N, N));
        repeat (2) @(posedge clk);
        #1;

        // reset state, then single push retired with ack held
        add(vi(N, N, 8'h00, 8'h00, N, 8'h00, 8'h00, N, N), vo(Y, 8'h00, N, N, 8'h00, 8'h00, 3'd0, N, N));
        add(vi(N, Y, 8'h10, 8'hAA, N, 8'h00, 8'h00, Y, N), vo(Y, 8'h00, N, N, 8'h00, 8'h00, 3'd0, N, N));
        add(vi(N, N, 8'h00, 8'h00, N, 8'h00, 8'h00, Y, N), vo(Y, 8'h00, N, Y, 8'h10, 8'hAA, 3'd1, N, N));
        add(vi(N, N, 8'h00, 8'h00, N, 8'h00, 8'h00, N, N), vo(Y, 8'h00, N, N, 8'h00, 8'h00, 3'd0, N, N));
        // forwarding: youngest match wins, same-cycle push invisible, miss path
        add(vi(N, Y, 8'h05, 8'h11, N, 8'h00, 8'h00, N, N), vo(Y, 8'h00, N, N, 8'h00, 8'h00, 3'd0, N, N));
        add(vi(N, Y, 8'h05, 8'h22, Y, 8'h05, 8'h33, N, N), vo(Y, 8'h11, N, Y, 8'h05, 8'h11, 3'd1, N, N));
        add(vi(N, N, 8'h00, 8'h00, Y, 8'h05, 8'h33, N, N), vo(Y, 8'h22, N, Y, 8'h05, 8'h11, 3'd2, N, N));
        add(vi(N, N, 8'h00, 8'h00, Y, 8'h06, 8'h7E, N, N), vo(Y, 8'h7E, Y, Y, 8'h05, 8'h11, 3'd2, N, N));
        // fill to DEPTH, overflow drop, data intact
        add(vi(N, Y, 8'h30, 8'hC3, N, 8'h00, 8'h00, N, N), vo(Y, 8'h00, N, Y, 8'h05, 8'h11, 3'd2, N, N));
        add(vi(N, Y, 8'h40, 8'hD4, N, 8'h00, 8'h00, N, N), vo(Y, 8'h00, N, Y, 8'h05, 8'h11, 3'd3, N, N));
        add(vi(N, Y, 8'h50, 8'hE5, N, 8'h00, 8'h00, N, N), vo(N, 8'h00, N, Y, 8'h05, 8'h11, 3'd4, N, N));
        add(vi(N, N, 8'h00, 8'h00, Y, 8'h40, 8'h00, N, N), vo(N, 8'hD4, N, Y, 8'h05, 8'h11, 3'd4, Y, N));
        add(vi(N, N, 8'h00, 8'h00, Y, 8'h50, 8'h9A, N, N), vo(N, 8'h9A, Y, Y, 8'h05, 8'h11, 3'd4, Y, N));
        add(vi(N, N, 8'h00, 8'h00, Y, 8'h30, 8'h00, Y, N), vo(N, 8'hC3, N, Y, 8'h05, 8'h11, 3'd4, Y, N));
        add(vi(N, N, 8'h00, 8'h00, N, 8'h00, 8'h00, Y, N), vo(Y, 8'h00, N, Y, 8'h05, 8'h22, 3'd3, Y, N));
        add(vi(N, N, 8'h00, 8'h00, N, 8'h00, 8'h00, Y, N), vo(Y, 8'h00, N, Y, 8'h30, 8'hC3, 3'd2, Y, N));
        add(vi(N, N, 8'h00, 8'h00, N, 8'h00, 8'h00, Y, N), vo(Y, 8'h00, N, Y, 8'h40, 8'hD4, 3'd1, Y, N));
        add(vi(N, N, 8'h00, 8'h00, N, 8'h00, 8'h00, N, N), vo(Y, 8'h00, N, N, 8'h00, 8'h00, 3'd0, Y, N));
        // wrap-around: six pushes, ack on alternate cycles, in-order retire
        add(vi(N, Y, 8'hA0, 8'h00, N, 8'h00, 8'h00, N, N), vo(Y, 8'h00, N, N, 8'h00, 8'h00, 3'd0, Y, N));
        add(vi(N, Y, 8'hA1, 8'h01, N, 8'h00, 8'h00, Y, N), vo(Y, 8'h00, N, Y, 8'hA0, 8'h00, 3'd1, Y, N));
        add(vi(N, Y, 8'hA2, 8'h02, N, 8'h00, 8'h00, N, N), vo(Y, 8'h00, N, Y, 8'hA1, 8'h01, 3'd1, Y, N));
        add(vi(N, Y, 8'hA3, 8'h03, N, 8'h00, 8'h00, Y, N), vo(Y, 8'h00, N, Y, 8'hA1, 8'h01, 3'd2, Y, N));
        add(vi(N, Y, 8'hA4, 8'h04, N, 8'h00, 8'h00, N, N), vo(Y, 8'h00, N, Y, 8'hA2, 8'h02, 3'd2, Y, N));
        add(vi(N, Y, 8'hA5, 8'h05, N, 8'h00, 8'h00, Y, N), vo(Y, 8'h00, N, Y, 8'hA2, 8'h02, 3'd3, Y, N));
        add(vi(N, N, 8'h00, 8'h00, N, 8'h00, 8'h00, Y, N), vo(Y, 8'h00, N, Y, 8'hA3, 8'h03, 3'd3, Y, N));
        add(vi(N, N, 8'h00, 8'h00, N, 8'h00, 8'h00, N, N), vo(Y, 8'h00, N, Y, 8'hA4, 8'h04, 3'd2, Y, N));
        add(vi(N, N, 8'h00, 8'h00, N, 8'h00, 8'h00, Y, N), vo(Y, 8'h00, N, Y, 8'hA4, 8'h04, 3'd2, Y, N));
        add(vi(N, N, 8'h00, 8'h00, N, 8'h00, 8'h00, Y, N), vo(Y, 8'h00, N, Y, 8'hA5, 8'h05, 3'd1, Y, N));
        add(vi(N, N, 8'h00, 8'h00, N, 8'h00, 8'h00, N, N), vo(Y, 8'h00, N, N, 8'h00, 8'h00, 3'd0, Y, N));
        // drain with three entries and ack held: pushes blocked, pulse four cycles later
        add(vi(N, Y, 8'hB0, 8'h10, N, 8'h00, 8'h00, N, N), vo(Y, 8'h00, N, N, 8'h00, 8'h00, 3'd0, Y, N));
        add(vi(N, Y, 8'hB1, 8'h11, N, 8'h00, 8'h00, N, N), vo(Y, 8'h00, N, Y, 8'hB0, 8'h10, 3'd1, Y, N));
        add(vi(N, Y, 8'hB2, 8'h12, N, 8'h00, 8'h00, N, N), vo(Y, 8'h00, N, Y, 8'hB0, 8'h10, 3'd2, Y, N));
        add(vi(N, N, 8'h00, 8'h00, N, 8'h00, 8'h00, Y, Y), vo(Y, 8'h00, N, Y, 8'hB0, 8'h10, 3'd3, Y, N));
        add(vi(N, Y, 8'hC0, 8'hCC, N, 8'h00, 8'h00, Y, N), vo(N, 8'h00, N, Y, 8'hB1, 8'h11, 3'd2, Y, N));
        add(vi(N, N, 8'h00, 8'h00, N, 8'h00, 8'h00, Y, N), vo(N, 8'h00, N, Y, 8'hB2, 8'h12, 3'd1, Y, N));
        add(vi(N, N, 8'h00, 8'h00, N, 8'h00, 8'h00, Y, N), vo(N, 8'h00, N, N, 8'h00, 8'h00, 3'd0, Y, N));
        add(vi(N, N, 8'h00, 8'h00, N, 8'h00, 8'h00, Y, Y), vo(N, 8'h00, N, N, 8'h00, 8'h00, 3'd0, Y, Y));
        add(vi(N, N, 8'h00, 8'h00, N, 8'h00, 8'h00, N, N), vo(Y, 8'h00, N, N, 8'h00, 8'h00, 3'd0, Y, N));
        // drain while empty goes straight to DONE
        add(vi(N, N, 8'h00, 8'h00, N, 8'h00, 8'h00, N, Y), vo(Y, 8'h00, N, N, 8'h00, 8'h00, 3'd0, Y, N));
        add(vi(N, N, 8'h00, 8'h00, N, 8'h00, 8'h00, N, N), vo(N, 8'h00, N, N, 8'h00, 8'h00, 3'd0, Y, Y));
        add(vi(N, N, 8'h00, 8'h00, N, 8'h00, 8'h00, N, N), vo(Y, 8'h00, N, N, 8'h00, 8'h00, 3'd0, Y, N));
        // reset with two entries buffered discards them
        add(vi(N, Y, 8'hD0, 8'h41, N, 8'h00, 8'h00, N, N), vo(Y, 8'h00, N, N, 8'h00, 8'h00, 3'd0, Y, N));
        add(vi(N, Y, 8'hD1, 8'h42, N, 8'h00, 8'h00, N, N), vo(Y, 8'h00, N, Y, 8'hD0, 8'h41, 3'd1, Y, N));
        add(vi(Y, N, 8'h00, 8'h00, N, 8'h00, 8'h00, N, N), vo(Y, 8'h00, N, Y, 8'hD0, 8'h41, 3'd2, Y, N));
        add(vi(N, N, 8'h00, 8'h00, Y, 8'hD0, 8'h55, N, N), vo(Y, 8'h55, Y, N, 8'h00, 8'h00, 3'd0, N, N));

        foreach (tbl[i]) begin
            apply(tbl[i].i);
            @(negedge clk);
            got = sample();
            if (!tbl[i].o.dnw_en) begin
                got.dwa = 8'h00;
                got.dwd = 8'h00;
            end
            check_vec($sformatf("vec%0d", i), got, tbl[i].o);
            @(posedge clk);
            #1;
        end

        // drain with two entries and two stalled ack cycles: 2 + 2 + 1 = 5
        apply(vi(N, Y, 8'hE0, 8'h01, N, 8'h00, 8'h00, N, N));
        @(posedge clk);
        #1;
        apply(vi(N, Y, 8'hE1, 8'h02, N, 8'h00, 8'h00, N, N));
        @(posedge clk);
        #1;
        first  = -1;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            apply(vi(N, N, 8'h00, 8'h00, N, 8'h00, 8'h00, (c >= 2) ? Y : N, (c == 0) ? Y : N));
            @(negedge clk);
            if (drained) begin
                pulses++;
                if (first < 0) first = c;
            end
            @(posedge clk);
            #1;
        end
        check_int("drain_latency", first, 5);
        check_int("drain_pulses", pulses, 1);
        check_int("count_after_drain", int'(count), 0);
        check_int("err_after_drain", int'(err_ovf), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
